// File: rtl/sfu_drain_pkg.sv
// Shared definitions for the SFU read-out path: drain FSM encoding and the
// requantize width defaults that the SFU side also builds against.
package sfu_drain_pkg;

    localparam int SFU_BW       = 4;
    localparam int SFU_PSUM_BW  = 16;
    localparam int SFU_INPUT_CH = 16;
    localparam int SFU_SHIFT    = 4;
    localparam int SFU_ADDR_BW  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2,
        WRITE = 2'd3
    } drain_state_t;

endpackage

// File: rtl/sfu_drain_if.sv
// Bundle between the drain block, the SFU read port and the output-activation SRAM
// write port. master = drain block, slave = its surroundings.
interface sfu_drain_if #(
    parameter int bw       = sfu_drain_pkg::SFU_BW,
    parameter int psum_bw  = sfu_drain_pkg::SFU_PSUM_BW,
    parameter int input_ch = sfu_drain_pkg::SFU_INPUT_CH,
    parameter int addr_bw  = sfu_drain_pkg::SFU_ADDR_BW
);

    logic                     start;
    logic                     busy;
    logic                     done;
    logic                     out_en;
    logic [psum_bw-1:0]       psum_out;
    logic                     mem_wen;
    logic [addr_bw-1:0]       mem_addr;
    logic [input_ch*bw-1:0]   mem_wdata;

    modport master (
        input  start, psum_out,
        output out_en, mem_wen, mem_addr, mem_wdata, busy, done
    );

    modport slave (
        output start, psum_out,
        input  out_en, mem_wen, mem_addr, mem_wdata, busy, done
    );

endinterface

// File: rtl/sfu_drain_requant.sv
// Requantizer for one SFU psum: arithmetic right shift, then unsigned saturation
// to bw bits. Negative inputs clamp to zero.
module sfu_requant
    import sfu_drain_pkg::*;
#(
    parameter int psum_bw = SFU_PSUM_BW,
    parameter int bw      = SFU_BW,
    parameter int shift   = SFU_SHIFT
) (
    input  logic signed [psum_bw-1:0] psum,
    output logic        [bw-1:0]      q
);

    function automatic logic [bw-1:0] requant_sat(input logic signed [psum_bw-1:0] v);
        logic signed [psum_bw-1:0] shifted;
        logic        [bw-1:0]      res;
        shifted = v >>> shift;
        if (v[psum_bw-1])
            res = '0;
        else if (|shifted[psum_bw-1:bw])
            res = '1;
        else
            res = shifted[bw-1:0];
        return res;
    endfunction

    assign q = requant_sat(psum);

endmodule

// File: rtl/sfu_drain.sv
// Drains one row of the SFU accumulator bank: bursts out_en, captures the returned
// psums, requantizes and packs them, and writes the row to the output SRAM.
module sfu_drain
    import sfu_drain_pkg::*;
#(
    parameter int bw       = SFU_BW,
    parameter int psum_bw  = SFU_PSUM_BW,
    parameter int input_ch = SFU_INPUT_CH,
    parameter int shift    = SFU_SHIFT,
    parameter int addr_bw  = SFU_ADDR_BW
) (
    input  logic        clk,
    input  logic        reset_n,
    sfu_drain_if.master bus
);

    localparam int                 IDX_W    = (input_ch > 1) ? $clog2(input_ch) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(input_ch - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE  = 1;
    localparam logic [addr_bw-1:0] ADDR_ONE = 1;

    drain_state_t           state, state_nxt;
    logic [IDX_W-1:0]       en_cnt;
    logic [IDX_W-1:0]       cap_idx;
    logic                   out_en_r;
    logic                   vld_p1;
    logic                   wen_r;
    logic                   busy_r;
    logic [addr_bw-1:0]     mem_addr_r;
    logic [input_ch*bw-1:0] pack_r;
    logic [input_ch*bw-1:0] pack_nxt;
    logic [input_ch*bw-1:0] wdata_r;
    logic [bw-1:0]          q_p1;

    sfu_requant #(
        .psum_bw (psum_bw),
        .bw      (bw),
        .shift   (shift)
    ) u_requant (
        .psum (bus.psum_out),
        .q    (q_p1)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = DRAIN;
            DRAIN:   if (en_cnt == LAST_IDX) state_nxt = FLUSH;
            FLUSH:   state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p1 stage: psum_out arrives one cycle after out_en, so the slot index follows vld_p1
    always_comb begin
        pack_nxt = pack_r;
        if (vld_p1)
            pack_nxt[cap_idx*bw +: bw] = q_p1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            out_en_r   <= 1'b0;
            vld_p1     <= 1'b0;
            wen_r      <= 1'b0;
            busy_r     <= 1'b0;
            en_cnt     <= '0;
            cap_idx    <= '0;
            mem_addr_r <= '0;
            pack_r     <= '0;
            wdata_r    <= '0;
        end else begin
            state    <= state_nxt;
            out_en_r <= (state_nxt == DRAIN);
            vld_p1   <= out_en_r;
            wen_r    <= (state_nxt == WRITE);
            busy_r   <= (state_nxt != IDLE);

            if (state == DRAIN)
                en_cnt <= (en_cnt == LAST_IDX) ? '0 : en_cnt + IDX_ONE;
            else
                en_cnt <= '0;

            if (vld_p1)
                cap_idx <= (cap_idx == LAST_IDX) ? '0 : cap_idx + IDX_ONE;

            pack_r <= pack_nxt;

            // Last capture lands in the same edge that enters WRITE, so latch the merged row
            if (state == FLUSH)
                wdata_r <= pack_nxt;

            if (state == WRITE)
                mem_addr_r <= mem_addr_r + ADDR_ONE;
        end
    end

    assign bus.out_en    = out_en_r;
    assign bus.mem_wen   = wen_r;
    assign bus.done      = wen_r;
    assign bus.busy      = busy_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_sfu_drain.sv
// Directed bench for sfu_drain with a registered SFU read-port model feeding psum_out.
module tb_sfu_drain;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    int          cyc     = 0;
    int          checks  = 0;
    int          failures = 0;
    int          wen_cnt = 0;
    logic [15:0] bank [16];
    logic [3:0]  sfu_ptr;
    int          w0;

    sfu_drain_if bus ();

    sfu_drain dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SFU read port: registers bank[out_ptr] on each out_en edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sfu_ptr      <= 4'd0;
            bus.psum_out <= 16'd0;
        end else if (bus.out_en) begin
            bus.psum_out <= bank[sfu_ptr];
            sfu_ptr      <= sfu_ptr + 4'd1;
        end
    end

    always @(negedge clk) if (bus.mem_wen) wen_cnt++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        checks++;
        if (obs !== expd) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    task automatic load_ramp(input int r);
        for (int k = 0; k < 16; k++)
            bank[k] = 16'(((k + r) & 15) << 4);
    endtask

    task automatic run_row(input string tag, input logic [63:0] exp_data,
                           input logic [10:0] exp_addr, input bit poke);
        int s, rel, en_cycles, first_en, lat, wen_start;
        bit seen;
        en_cycles = 0; first_en = -1; lat = -1; seen = 1'b0; wen_start = wen_cnt;
        @(negedge clk);
        s = cyc;
        bus.start = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            rel = cyc - s;
            bus.start = poke && (rel == 5);
            if (bus.out_en) begin
                en_cycles++;
                if (first_en < 0) first_en = rel;
            end
            if (bus.mem_wen) begin
                seen = 1'b1;
                lat  = rel;
                check({tag, "_addr"}, 64'(bus.mem_addr), 64'(exp_addr));
                check({tag, "_data"}, bus.mem_wdata, exp_data);
                check({tag, "_done"}, 64'(bus.done), 64'd1);
            end
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd18);
        check({tag, "_en_cycles"}, 64'(en_cycles), 64'd16);
        check({tag, "_first_en"}, 64'(first_en), 64'd1);
        if (poke) begin
            check({tag, "_busy_write"}, 64'(bus.busy), 64'd1);
            @(negedge clk);
            check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
            repeat (25) @(negedge clk);
            check({tag, "_one_write"}, 64'(wen_cnt - wen_start), 64'd1);
        end
    endtask

    task automatic pump_rows(input int n);
        int rows_done;
        rows_done = 0;
        for (int r = 0; r < n; r++) begin
            @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.mem_wen) begin
                    rows_done++;
                    break;
                end
            end
        end
        check("pump_rows", 64'(rows_done), 64'(n));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_en"}, 64'(bus.out_en), 64'd0);
        check({tag, "_mem_wen"}, 64'(bus.mem_wen), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        load_ramp(0);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        run_row("basic", 64'hFEDC_BA98_7654_3210, 11'd0, 1'b0);

        bank = '{16'h0100, 16'h8000, 16'h000F, 16'h7FFF, 16'h00F0, 16'h00FF, 16'h0010, 16'hFFFF,
                 16'h0020, 16'h0030, 16'h0012, 16'h00A5, 16'h0200, 16'h4000, 16'h0000, 16'h0051};
        run_row("sat", 64'h50FF_A132_01FF_F00F, 11'd1, 1'b0);
        repeat (3) @(negedge clk);
        check("wdata_hold", bus.mem_wdata, 64'h50FF_A132_01FF_F00F);
        check("addr_inc", 64'(bus.mem_addr), 64'd2);

        load_ramp(0);
        run_row("busy_start", 64'hFEDC_BA98_7654_3210, 11'd2, 1'b1);

        // Reset in the middle of a drain burst
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_row_busy", 64'(bus.busy), 64'd1);
        check("mid_row_out_en", 64'(bus.out_en), 64'd1);
        w0 = wen_cnt;
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("reset_no_write", 64'(wen_cnt - w0), 64'd0);
        check("reset_idle_busy", 64'(bus.busy), 64'd0);

        load_ramp(0);
        run_row("b2b0", 64'hFEDC_BA98_7654_3210, 11'd0, 1'b0);
        load_ramp(1);
        run_row("b2b1", 64'h0FED_CBA9_8765_4321, 11'd1, 1'b0);
        load_ramp(2);
        run_row("b2b2", 64'h10FE_DCBA_9876_5432, 11'd2, 1'b0);

        pump_rows(2044);
        load_ramp(0);
        run_row("wrap_hi", 64'hFEDC_BA98_7654_3210, 11'h7FF, 1'b0);
        run_row("wrap_lo", 64'hFEDC_BA98_7654_3210, 11'h000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
